// File: rtl/s2_word_accumulator.sv
// s2_word_accumulator: sums LEN words from the S2 register stage and hands the sum off on a valid/ready port
module s2_word_accumulator #(
    parameter int N   = 8,
    parameter int LEN = 4
) (
    input  logic                       clk,
    input  logic                       clr_n,
    input  logic                       in_valid,
    input  logic [N-1:0]               in_data,
    output logic                       in_ready,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N+$clog2(LEN)-1:0]   out_sum,
    output logic [$clog2(LEN+1)-1:0]   out_cnt
);
    localparam int W = N + $clog2(LEN);
    localparam int C = $clog2(LEN + 1);

    typedef enum logic {ACC, DONE} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [C-1:0]   cnt_q, cnt_d;

    // next state: accumulate in ACC, close the group on the LEN-th word or a non-empty flush, clear on handshake
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        if (state_q == ACC) begin
            acc_d = in_valid ? acc_q + W'(in_data) : acc_q;
            cnt_d = in_valid ? cnt_q + C'(1) : cnt_q;
            state_d = (cnt_d == C'(LEN) || (flush && cnt_d != '0)) ? DONE : ACC;
        end else if (out_ready) begin
            state_d = ACC;
            acc_d   = '0;
            cnt_d   = '0;
        end
    end

    // state and datapath registers; reset discards any partial or pending result
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q <= ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == DONE);
    assign out_sum   = acc_q;
    assign out_cnt   = cnt_q;
endmodule

// File: doc/s2_word_accumulator.md
# s2_word_accumulator

Downstream consumer of the registered S2 mux stage. It accepts a stream of N-bit words from the S2 output register and accumulates LEN words into a widened sum. It then presents the sum and the word count on a valid/ready output port. An early flush emits a partial sum.

## Interface
- N, 8: data word width; matches the upstream S2 width.
- LEN, 4: words per accumulation; legal range 2..255.
- W, N+$clog2(LEN) (derived, localparam): sum width; holds LEN*(2^N-1) without overflow.
- C, $clog2(LEN+1) (derived, localparam): count width.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- clr_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  upstream word present on in_data.
- in_data  input  N  word from the S2 output register.
- in_ready  output  1  block accepts a word this cycle.
- flush  input  1  request early emission of the partial sum.
- out_valid  output  1  out_sum/out_cnt valid.
- out_ready  input  1  downstream takes the result.
- out_sum  output  W  accumulated sum, unsigned.
- out_cnt  output  C  number of words in out_sum.

## Operation
- Two-state FSM: ACC and DONE. All state and outputs are registered. in_ready and out_valid decode directly from the state register.
- Reset: any rising edge with clr_n=0 forces state=ACC, acc=0, cnt=0. After that edge: in_ready=1, out_valid=0, out_sum=0, out_cnt=0. Reset wins over every other input and discards any partial sum or pending result.
- ACC behaviour:
  - in_ready=1 and out_valid=0.
  - A word is accepted when in_valid=1: acc <= acc + zero-extended in_data and cnt <= cnt+1. Unsigned arithmetic, no saturation needed because W covers the worst case.
  - Gaps in in_valid are allowed; acc and cnt hold.
- ACC to DONE transitions:
  - When the accepted word makes cnt reach LEN.
  - When flush=1 and the post-edge cnt is at least 1. A word accepted in the same cycle is included.
  - flush with cnt=0 and no word accepted is ignored; the block stays in ACC.
- DONE behaviour:
  - in_ready=0 and out_valid=1.
  - out_sum=acc and out_cnt=cnt; both are held stable.
  - in_valid and flush are ignored.
- DONE to ACC: on out_ready=1, acc and cnt clear to 0.
- out_sum and out_cnt are the acc/cnt registers and are observable in every state. They carry no meaning unless out_valid=1.

## Timing
- Accept throughput: 1 word per cycle in ACC.
- Latency: out_valid rises on the edge that accepts the LEN-th word (or the flush edge) and is visible in the following cycle.
- DONE lasts at least 1 cycle. The handshake completes on the edge where out_valid=1 and out_ready=1.
- in_ready returns to 1 in the cycle after the handshake, giving a minimum 1-cycle bubble between groups.
- Best-case group period: LEN+1 cycles.
- out_ready may be held high permanently; it has no effect in ACC.
- Upstream must hold in_data while in_valid=1 and in_ready=0. The S2 register satisfies this by gating its clear/load with in_ready.

## Test plan
N=8, LEN=4, W=10, C=3.
- Reset: hold clr_n=0 for 2 cycles with in_valid=1 and in_data=0xFF -> after release, in_ready=1, out_valid=0, out_sum=0, out_cnt=0. No word is counted during reset.
- Full group: words 10,20,30,40 back-to-back, out_ready=1 -> out_valid=1 for exactly 1 cycle, starting the cycle after 40 is accepted, with out_sum=100 and out_cnt=4. in_ready=1 again one cycle later.
- Width bound: 4×255 -> out_sum=1020. A second group of 1,2,3,4 -> 10, confirming acc cleared.
- Backpressure: complete a group of 5,5,5,5 with out_ready=0 for 6 cycles while in_valid=1, in_data=99 -> out_valid, out_sum=20 and out_cnt=4 stay stable and in_ready=0. On out_ready=1 the handshake completes, and the 99 word is accepted only after in_ready returns.
- Flush cases, each ending with out_ready=1:
  - 7,9 then flush alone -> out_sum=16, out_cnt=2.
  - 7, then flush together with in_valid, in_data=5 -> out_sum=12, out_cnt=2.
  - flush with cnt=0 -> no out_valid.
- Reset mid-operation:
  - clr_n=0 after 3 words -> out_sum=0, out_cnt=0. A following 1,1,1,1 gives out_sum=4, out_cnt=4.
  - clr_n=0 while in DONE -> out_valid drops on that edge.
